riscv_if_parcel_queue: RTL and testbench

RISCV_IF_PARCEL_QUEUE -- requirements
Module: riscv_if_parcel_queue

---
 rtl/riscv_if_pkg.sv | 19 +
 rtl/riscv_if_parcel_queue.sv | 112 +++++++++++
 tb/tb_riscv_if_parcel_queue.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_if_pkg.sv
// Fetch-side types shared between the instruction-fetch parcel queue and decode.
package riscv_if_pkg;

    localparam int IF_XLEN        = 32;
    localparam int IF_PARCEL_SIZE = 32;

    // Decode consumes this layout directly, so its field widths are fixed here.
    typedef struct packed {
        logic [IF_XLEN-1:0]        pc;
        logic [IF_PARCEL_SIZE-1:0] parcel;
        logic                      misaligned;
    } parcel_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        LOCKED = 1'b1
    } pq_state_t;

endpackage

// File: rtl/riscv_if_parcel_queue.sv
// Parcel queue between the icache and decode. Stalls one entry early and locks
// after a misaligned parcel until the pipeline flushes.
module riscv_if_parcel_queue
    import riscv_if_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PARCEL_SIZE = 32,
    parameter int DEPTH       = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     if_flush,
    input  logic                     if_parcel_valid,
    input  logic [XLEN-1:0]          if_parcel_pc,
    input  logic [PARCEL_SIZE-1:0]   if_parcel,
    input  logic                     if_parcel_misaligned,
    output logic                     if_stall,
    output logic                     pq_valid,
    output logic [XLEN-1:0]          pq_pc,
    output logic [PARCEL_SIZE-1:0]   pq_parcel,
    output logic                     pq_misaligned,
    input  logic                     pq_ready,
    output logic [$clog2(DEPTH):0]   pq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    parcel_entry_t mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    pq_state_t     state_q, state_d;

    logic          lock;
    logic          full;
    logic          push;
    logic          pop;
    parcel_entry_t wr_entry;
    parcel_entry_t head;

    assign lock = (state_q == LOCKED);
    assign full = (count_q == CW'(DEPTH));

    assign pq_valid = (count_q != '0) && !if_flush;
    assign pop      = pq_valid && pq_ready;
    assign push     = if_parcel_valid && !if_flush && !lock && (!full || pop);

    // Stall one entry early: the icache still delivers the parcel already in flight.
    assign if_stall = (count_q >= CW'(DEPTH - 1)) || lock;
    assign pq_count = count_q;

    assign head          = mem[rd_ptr_q];
    assign pq_pc         = head.pc;
    assign pq_parcel     = head.parcel;
    assign pq_misaligned = head.misaligned;

    always_comb begin
        wr_entry.pc         = if_parcel_pc;
        wr_entry.parcel     = if_parcel;
        wr_entry.misaligned = if_parcel_misaligned;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        state_d  = state_q;

        if (if_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            state_d  = RUN;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push && if_parcel_misaligned) state_d = LOCKED;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // NOTE: storage has no reset; count and pointers alone define which
    // entries are live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

endmodule

// File: tb/tb_riscv_if_parcel_queue.sv
// Directed bench for the fetch parcel queue: fill/stall, full push+pop, lock,
// flush, streaming wrap-around and asynchronous reset.
module tb_riscv_if_parcel_queue;

    localparam int XLEN        = 32;
    localparam int PARCEL_SIZE = 32;
    localparam int DEPTH       = 4;

    logic                   ACLK;
    logic                   ARESETn;
    logic                   if_flush;
    logic                   if_parcel_valid;
    logic [XLEN-1:0]        if_parcel_pc;
    logic [PARCEL_SIZE-1:0] if_parcel;
    logic                   if_parcel_misaligned;
    logic                   if_stall;
    logic                   pq_valid;
    logic [XLEN-1:0]        pq_pc;
    logic [PARCEL_SIZE-1:0] pq_parcel;
    logic                   pq_misaligned;
    logic                   pq_ready;
    logic [$clog2(DEPTH):0] pq_count;

    int total = 0;
    int bad   = 0;
    int full_drops = 0;

    riscv_if_parcel_queue #(
        .XLEN        (XLEN),
        .PARCEL_SIZE (PARCEL_SIZE),
        .DEPTH       (DEPTH)
    ) dut (
        .ACLK                 (ACLK),
        .ARESETn              (ARESETn),
        .if_flush             (if_flush),
        .if_parcel_valid      (if_parcel_valid),
        .if_parcel_pc         (if_parcel_pc),
        .if_parcel            (if_parcel),
        .if_parcel_misaligned (if_parcel_misaligned),
        .if_stall             (if_stall),
        .pq_valid             (pq_valid),
        .pq_pc                (pq_pc),
        .pq_parcel            (pq_parcel),
        .pq_misaligned        (pq_misaligned),
        .pq_ready             (pq_ready),
        .pq_count             (pq_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Flags every push the icache attempts while the queue is full and not draining.
    always @(posedge ACLK) begin
        if (ARESETn && if_parcel_valid && !if_flush &&
            (pq_count == DEPTH) && !(pq_valid && pq_ready))
            full_drops++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs; outputs are sampled 1ns later, well before the edge.
    task automatic drive(input logic valid, input logic [31:0] pc, input logic mis,
                         input logic ready, input logic flush);
        if_parcel_valid      = valid;
        if_parcel_pc         = pc;
        if_parcel            = pc ^ 32'hA5A5_0000;
        if_parcel_misaligned = mis;
        pq_ready             = ready;
        if_flush             = flush;
        #1;
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        ARESETn = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("rst_valid", 32'(pq_valid), 32'd0);
        check("rst_count", 32'(pq_count), 32'd0);
        check("rst_stall", 32'(if_stall), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        step();

        // Three pushes with decode stalled; first push is not visible in its own cycle.
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        check("no_bypass", 32'(pq_valid), 32'd0);
        step();
        check("latency_valid", 32'(pq_valid), 32'd1);
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("fill3_count", 32'(pq_count), 32'd3);
        check("fill3_stall", 32'(if_stall), 32'd1);
        check("fill3_pc", pq_pc, 32'h100);
        check("fill3_parcel", pq_parcel, 32'h100 ^ 32'hA5A5_0000);

        // Fill to DEPTH, then a push without a pop is dropped.
        drive(1'b1, 32'h10C, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("full_count", 32'(pq_count), 32'd4);
        drive(1'b1, 32'h1F0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("drop_count", 32'(pq_count), 32'd4);
        check("drop_head", pq_pc, 32'h100);
        check("drop_flagged", 32'(full_drops), 32'd1);

        // Full plus simultaneous push and pop: accepted, count stays at DEPTH.
        drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("fullpp_count", 32'(pq_count), 32'd4);
        check("fullpp_head", pq_pc, 32'h104);
        check("fullpp_no_drop", 32'(full_drops), 32'd1);

        // Drain; the dropped 0x1F0 must never appear.
        begin
            logic [31:0] exp_pc [4];
            exp_pc = '{32'h104, 32'h108, 32'h10C, 32'h200};
            for (int i = 0; i < 4; i++) begin
                drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
                check($sformatf("drain_pc%0d", i), pq_pc, exp_pc[i]);
                step();
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("drain_empty", 32'(pq_valid), 32'd0);
        check("drain_stall", 32'(if_stall), 32'd0);

        // Misaligned push locks the queue until flush.
        drive(1'b1, 32'h102, 1'b1, 1'b0, 1'b0); step();
        drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
        check("lock_stall", 32'(if_stall), 32'd1);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("lock_drop_count", 32'(pq_count), 32'd1);
        check("lock_head_pc", pq_pc, 32'h102);
        check("lock_head_mis", 32'(pq_misaligned), 32'd1);
        step();
        check("lock_stall_held", 32'(if_stall), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("lock_flush_valid", 32'(pq_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("unlock_stall", 32'(if_stall), 32'd0);
        check("unlock_count", 32'(pq_count), 32'd0);

        // Flush with count=3 and a simultaneous push.
        drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h304, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h308, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h30C, 1'b0, 1'b1, 1'b1);
        check("flush_pre_count", 32'(pq_count), 32'd3);
        check("flush_valid", 32'(pq_valid), 32'd0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("flush_count", 32'(pq_count), 32'd0);
        step();
        check("flush_discard", 32'(pq_count), 32'd0);
        check("flush_discard_v", 32'(pq_valid), 32'd0);

        // Streaming: 10 parcels, one in flight, pointers wrap.
        drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0); step();
        for (int k = 1; k < 10; k++) begin
            drive(1'b1, 32'(4 * k), 1'b0, 1'b1, 1'b0);
            check($sformatf("stream_pc%0d", k - 1), pq_pc, 32'(4 * (k - 1)));
            check($sformatf("stream_cnt%0d", k - 1), 32'(pq_count), 32'd1);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("stream_pc9", pq_pc, 32'h24);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("stream_end_count", 32'(pq_count), 32'd0);

        // Asynchronous reset mid-stream with two entries queued.
        drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("arst_pre_count", 32'(pq_count), 32'd2);
        #1;
        ARESETn = 1'b0;
        #1;
        check("arst_valid", 32'(pq_valid), 32'd0);
        check("arst_count", 32'(pq_count), 32'd0);
        check("arst_stall", 32'(if_stall), 32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        step();
        check("arst_after_count", 32'(pq_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
